// File: rtl/pipelined_shifter_if.sv
// Handshake/bus bundle for pipelined_shifter: operation in, result out, flush.
interface pipelined_shifter_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [1:0]       op;
  logic             word;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  s;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, a, b, op, word, tag_in, flush, out_ready,
    input  in_ready, out_valid, s, tag_out
  );

  modport slave (
    input  in_valid, a, b, op, word, tag_in, flush, out_ready,
    output in_ready, out_valid, s, tag_out
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA barrel shifter, one shift-amount bit group per stage.
// Optional RV64 *W ops are enabled by defining SHIFT_WORD_OP_EN.
module pipelined_shifter #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input logic              clk,
  input logic              reset,
  pipelined_shifter_if.slave bus
);
  localparam int unsigned SH_W = $clog2(XLEN);
  localparam int unsigned L    = SH_W / STAGES;
  localparam logic [1:0]  OP_SRL = 2'b01;
  localparam logic [1:0]  OP_SRA = 2'b11;

  if (STAGES == 0 || (SH_W % STAGES) != 0) begin : g_bad_stages
    $error("pipelined_shifter: STAGES must divide $clog2(XLEN)");
  end

  logic [XLEN-1:0]   data_q [STAGES];
  logic [SH_W-1:0]   sh_q   [STAGES];
  logic [1:0]        op_q   [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [STAGES-1:0] valid_q;
  logic              adv;
  logic [XLEN-1:0]   entry_data;
  logic [SH_W-1:0]   entry_sh;
  logic              unused_c;

`ifdef SHIFT_WORD_OP_EN
  logic [STAGES-1:0] word_q;

  if (XLEN != 64) begin : g_bad_xlen
    $error("pipelined_shifter: SHIFT_WORD_OP_EN requires XLEN=64");
  end

  // Word ops run on a 32-bit operand pre-extended so full-width shifts give the W result
  always_comb begin
    entry_data = bus.a;
    entry_sh   = bus.b[SH_W-1:0];
    if (bus.word) begin
      entry_sh   = SH_W'(bus.b[4:0]);
      entry_data = (bus.op == OP_SRA) ? XLEN'($signed(bus.a[31:0])) : XLEN'(bus.a[31:0]);
    end
  end

  assign unused_c = ^{bus.b[XLEN-1:SH_W], sh_q[STAGES-1], op_q[STAGES-1], word_q[STAGES-1]};
`else
  assign entry_data = bus.a;
  assign entry_sh   = bus.b[SH_W-1:0];
  assign unused_c   = ^{bus.b[XLEN-1:SH_W], bus.word, sh_q[STAGES-1], op_q[STAGES-1]};
`endif

  // The whole pipe moves together; a stalled output freezes every stage
  assign adv           = bus.out_ready | ~valid_q[STAGES-1];
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.s         = data_q[STAGES-1];
  assign bus.tag_out   = tag_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [SH_W-1:0] GROUP_MASK = SH_W'(((1 << L) - 1) << (k * L));

    logic [XLEN-1:0]  din;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  data_d;
    logic [SH_W-1:0]  sh_d;
    logic [SH_W-1:0]  amt;
    logic [1:0]       op_d;
    logic [TAG_W-1:0] tag_d;
    logic             valid_d;
`ifdef SHIFT_WORD_OP_EN
    logic             word_d;
`endif

    if (k == 0) begin : g_head
      assign din     = entry_data;
      assign sh_d    = entry_sh;
      assign op_d    = bus.op;
      assign tag_d   = bus.tag_in;
      assign valid_d = bus.in_valid;
`ifdef SHIFT_WORD_OP_EN
      assign word_d  = bus.word;
`endif
    end else begin : g_tail
      assign din     = data_q[k-1];
      assign sh_d    = sh_q[k-1];
      assign op_d    = op_q[k-1];
      assign tag_d   = tag_q[k-1];
      assign valid_d = valid_q[k-1];
`ifdef SHIFT_WORD_OP_EN
      assign word_d  = word_q[k-1];
`endif
    end

    // Arithmetic shifts keep the sign bit in place, so later stages still fill correctly
    assign amt = sh_d & GROUP_MASK;

    always_comb begin
      shifted = din << amt;
      if (op_d == OP_SRL) begin
        shifted = din >> amt;
      end else if (op_d == OP_SRA) begin
        shifted = XLEN'($signed(din) >>> amt);
      end
      data_d = shifted;
`ifdef SHIFT_WORD_OP_EN
      if (k == STAGES - 1 && word_d) begin
        data_d = XLEN'($signed(shifted[31:0]));
      end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        sh_q[k]    <= '0;
        op_q[k]    <= '0;
        tag_q[k]   <= '0;
`ifdef SHIFT_WORD_OP_EN
        word_q[k]  <= 1'b0;
`endif
      end else if (bus.flush) begin
        valid_q[k] <= 1'b0;
      end else if (adv) begin
        valid_q[k] <= valid_d;
        data_q[k]  <= data_d;
        sh_q[k]    <= sh_d;
        op_q[k]    <= op_d;
        tag_q[k]   <= tag_d;
`ifdef SHIFT_WORD_OP_EN
        word_q[k]  <= word_d;
`endif
      end
    end
  end
endmodule
